// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: operand forwarding for N EX-stage sources, load-use and
// long-op stall detection, a single-entry countdown scoreboard for the
// multi-cycle multiply/divide unit, and a saturating stall-cycle counter.
module hazard_fwd_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LO_LAT   = 4,
    parameter int STALL_CW = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic                        id_is_lo,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_src,
    input  logic [REG_AW-1:0]           ex_rd,
    input  logic                        ex_mem_read,
    input  logic                        lo_issue,
    input  logic [REG_AW-1:0]           exm_rd,
    input  logic                        exm_wr,
    input  logic [REG_AW-1:0]           wb_rd,
    input  logic                        wb_wr,
    output logic [2*NUM_SRC-1:0]        fwd_sel,
    output logic                        stall,
    output logic                        lo_busy,
    output logic                        lo_done,
    output logic [REG_AW-1:0]           lo_rd,
    output logic                        proto_err,
    output logic [STALL_CW-1:0]         stall_cnt
);

    localparam int CNT_W = $clog2(LO_LAT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LO_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } lo_state_e;

    lo_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [REG_AW-1:0]    lo_rd_q;
    logic                 lo_busy_q;
    logic                 lo_done_q;
    logic                 proto_err_q;
    logic [STALL_CW-1:0]  stall_cnt_q;
    logic [STALL_CW-1:0]  stall_cnt_d;

    // Long-op scoreboard: remaining-cycle countdown plus registered busy/done flags.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lo_rd_q     <= '0;
            lo_busy_q   <= 1'b0;
            lo_done_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (lo_issue) begin
                        state_q   <= S_BUSY;
                        cnt_q     <= CNT_INIT;
                        lo_rd_q   <= ex_rd;
                        lo_busy_q <= 1'b1;
                        // With a two-cycle latency the first busy cycle is already the done cycle.
                        lo_done_q <= (LO_LAT == 2);
                    end
                end
                S_BUSY: begin
                    // A second issue while the unit is occupied is dropped and flagged.
                    if (lo_issue) begin
                        proto_err_q <= 1'b1;
                    end
                    if (cnt_q == CNT_ONE) begin
                        state_q   <= S_IDLE;
                        cnt_q     <= '0;
                        lo_busy_q <= 1'b0;
                        lo_done_q <= 1'b0;
                    end else begin
                        cnt_q     <= cnt_q - CNT_ONE;
                        lo_done_q <= (cnt_q == CNT_TWO);
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    lo_busy_q <= 1'b0;
                    lo_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Per-operand forwarding select; EX/MEM beats the long unit, which beats MEM/WB.
    // NOTE: every combinational output gets a default before the conditional
    // logic so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (exm_wr && (exm_rd != '0) && (exm_rd == ex_src[i*REG_AW +: REG_AW])) begin
                fwd_sel[2*i +: 2] = 2'b10;
            end else if (lo_done_q && (lo_rd_q != '0) && (lo_rd_q == ex_src[i*REG_AW +: REG_AW])) begin
                fwd_sel[2*i +: 2] = 2'b11;
            end else if (wb_wr && (wb_rd != '0) && (wb_rd == ex_src[i*REG_AW +: REG_AW])) begin
                fwd_sel[2*i +: 2] = 2'b01;
            end else begin
                fwd_sel[2*i +: 2] = 2'b00;
            end
        end
    end

    // Stall: load-use, RAW on the long-op destination, or a second long op while busy.
    logic              load_use;
    logic              lo_raw;
    logic              trk_valid;
    logic [REG_AW-1:0] trk_rd;

    always_comb begin
        load_use  = 1'b0;
        lo_raw    = 1'b0;
        trk_valid = lo_busy_q || lo_issue;
        // An outstanding op owns the tracked destination; otherwise it is the op entering the unit.
        trk_rd    = lo_busy_q ? lo_rd_q : ex_rd;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i]) begin
                if (ex_mem_read && (ex_rd != '0) && (ex_rd == id_src[i*REG_AW +: REG_AW])) begin
                    load_use = 1'b1;
                end
                if (trk_valid && (trk_rd != '0) && (trk_rd == id_src[i*REG_AW +: REG_AW])) begin
                    lo_raw = 1'b1;
                end
            end
        end
        stall = load_use || lo_raw || (id_is_lo && lo_busy_q && !lo_done_q);
    end

    // Next stall-count value, holding at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall-cycle performance counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign lo_busy   = lo_busy_q;
    assign lo_done   = lo_done_q;
    assign lo_rd     = lo_rd_q;
    assign proto_err = proto_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed scenarios followed by random traffic, all
// compared every cycle against a cycle-numbered reference model.
module tb_hazard_fwd_unit;

    localparam int AW  = 5;
    localparam int NS  = 2;
    localparam int LAT = 4;
    localparam int SCW = 3;
    localparam int SMAX = (1 << SCW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NS*AW-1:0]    id_src;
    logic [NS-1:0]       id_src_used;
    logic                id_is_lo;
    logic [NS*AW-1:0]    ex_src;
    logic [AW-1:0]       ex_rd;
    logic                ex_mem_read;
    logic                lo_issue;
    logic [AW-1:0]       exm_rd;
    logic                exm_wr;
    logic [AW-1:0]       wb_rd;
    logic                wb_wr;
    logic [2*NS-1:0]     fwd_sel;
    logic                stall;
    logic                lo_busy;
    logic                lo_done;
    logic [AW-1:0]       lo_rd;
    logic                proto_err;
    logic [SCW-1:0]      stall_cnt;

    hazard_fwd_unit #(
        .REG_AW(AW), .NUM_SRC(NS), .LO_LAT(LAT), .STALL_CW(SCW)
    ) dut (
        .clk(clk), .rst(rst),
        .id_src(id_src), .id_src_used(id_src_used), .id_is_lo(id_is_lo),
        .ex_src(ex_src), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .lo_issue(lo_issue), .exm_rd(exm_rd), .exm_wr(exm_wr),
        .wb_rd(wb_rd), .wb_wr(wb_wr),
        .fwd_sel(fwd_sel), .stall(stall), .lo_busy(lo_busy), .lo_done(lo_done),
        .lo_rd(lo_rd), .proto_err(proto_err), .stall_cnt(stall_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the long op is described by the cycle numbers of its
    // issue and its completion rather than by a countdown.
    int          cyc        = 0;
    int          m_issue_at = -100;
    int          m_done_at  = -100;
    logic [AW-1:0] m_rd     = '0;
    bit          m_perr     = 1'b0;
    int          m_scnt     = 0;

    function automatic bit m_busy();
        return (cyc > m_issue_at) && (cyc <= m_done_at);
    endfunction

    function automatic bit m_done();
        return m_busy() && (cyc == m_done_at);
    endfunction

    function automatic logic [AW-1:0] fld(input logic [NS*AW-1:0] v, input int i);
        return v[i*AW +: AW];
    endfunction

    function automatic logic [2*NS-1:0] exp_fwd();
        logic [2*NS-1:0] f;
        logic [AW-1:0]   s;
        f = '0;
        for (int i = 0; i < NS; i++) begin
            s = fld(ex_src, i);
            if (exm_wr && exm_rd != 0 && exm_rd == s)          f[2*i +: 2] = 2'b10;
            else if (m_done() && m_rd != 0 && m_rd == s)       f[2*i +: 2] = 2'b11;
            else if (wb_wr && wb_rd != 0 && wb_rd == s)        f[2*i +: 2] = 2'b01;
            else                                               f[2*i +: 2] = 2'b00;
        end
        return f;
    endfunction

    function automatic bit exp_stall();
        bit            st;
        bit            have_trk;
        logic [AW-1:0] trk;
        logic [AW-1:0] s;
        st       = m_busy() && id_is_lo && !m_done();
        have_trk = m_busy() || lo_issue;
        trk      = m_busy() ? m_rd : ex_rd;
        for (int i = 0; i < NS; i++) begin
            s = fld(id_src, i);
            if (id_src_used[i]) begin
                if (ex_mem_read && ex_rd != 0 && ex_rd == s) st = 1'b1;
                if (have_trk && trk != 0 && trk == s)        st = 1'b1;
            end
        end
        return st;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clr();
        id_src = '0; id_src_used = '0; id_is_lo = 1'b0; ex_src = '0; ex_rd = '0;
        ex_mem_read = 1'b0; lo_issue = 1'b0; exm_rd = '0; exm_wr = 1'b0;
        wb_rd = '0; wb_wr = 1'b0;
    endtask

    // Compare every output with the model, away from the rising edge.
    task automatic sample();
        @(negedge clk);
        check("fwd_sel",   32'(fwd_sel),   32'(exp_fwd()));
        check("stall",     32'(stall),     32'(exp_stall()));
        check("lo_busy",   32'(lo_busy),   32'(m_busy()));
        check("lo_done",   32'(lo_done),   32'(m_done()));
        check("lo_rd",     32'(lo_rd),     32'(m_rd));
        check("proto_err", 32'(proto_err), 32'(m_perr));
        check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    endtask

    // Apply this cycle's inputs to the model, then move to the next cycle.
    task automatic advance();
        if (rst) begin
            m_issue_at = -100; m_done_at = -100; m_rd = '0; m_perr = 1'b0; m_scnt = 0;
        end else begin
            if (exp_stall() && m_scnt < SMAX) m_scnt++;
            if (lo_issue) begin
                if (m_busy()) begin
                    m_perr = 1'b1;
                end else begin
                    m_issue_at = cyc;
                    m_done_at  = cyc + LAT - 1;
                    m_rd       = ex_rd;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        advance();
        advance();
        rst = 1'b0;
        clr();
    endtask

    initial begin
        clr();
        do_reset();

        // Reset values with idle inputs.
        sample();
        check("rst_busy",  32'(lo_busy),   32'd0);
        check("rst_done",  32'(lo_done),   32'd0);
        check("rst_lo_rd", 32'(lo_rd),     32'd0);
        check("rst_perr",  32'(proto_err), 32'd0);
        check("rst_scnt",  32'(stall_cnt), 32'd0);
        check("rst_stall", 32'(stall),     32'd0);
        advance();

        // Forwarding priority: EX/MEM over MEM/WB, then MEM/WB alone, then r0.
        exm_wr = 1'b1; exm_rd = 5; wb_wr = 1'b1; wb_rd = 5; ex_src = {5'd0, 5'd5};
        sample(); check("fwd_exm", 32'(fwd_sel[1:0]), 32'b10); advance();
        exm_wr = 1'b0;
        sample(); check("fwd_wb",  32'(fwd_sel[1:0]), 32'b01); advance();
        exm_wr = 1'b1; exm_rd = 0; ex_src = {5'd0, 5'd0};
        sample(); check("fwd_r0",  32'(fwd_sel[1:0]), 32'b00); advance();
        clr();

        // Load-use on operand 1, then the same with operand unused.
        ex_mem_read = 1'b1; ex_rd = 8; id_src = {5'd8, 5'd0}; id_src_used = 2'b10;
        sample(); check("ld_use", 32'(stall), 32'd1); advance();
        id_src_used = 2'b00;
        sample(); check("ld_unused", 32'(stall), 32'd0); check("scnt_one", 32'(stall_cnt), 32'd1); advance();
        clr();

        // Long op to r12 with a dependent ID op; forward from the unit in the done cycle.
        lo_issue = 1'b1; ex_rd = 12; id_src = {5'd0, 5'd12}; id_src_used = 2'b01;
        sample(); check("lo_stall_c0", 32'(stall), 32'd1); advance();
        lo_issue = 1'b0; ex_rd = 0;
        sample(); check("lo_busy_c1", 32'(lo_busy), 32'd1); check("lo_done_c1", 32'(lo_done), 32'd0); advance();
        step();
        ex_src = {5'd0, 5'd12};
        sample();
        check("lo_done_c3", 32'(lo_done), 32'd1);
        check("lo_rd_c3",   32'(lo_rd),   32'd12);
        check("fwd_lo",     32'(fwd_sel[1:0]), 32'b11);
        check("lo_stall_c3", 32'(stall), 32'd1);
        advance();
        // Released cycle: no stall, and a new issue is legal right away.
        lo_issue = 1'b1; ex_rd = 6;
        sample(); check("lo_busy_c4", 32'(lo_busy), 32'd0); check("lo_rel_c4", 32'(stall), 32'd0); advance();
        lo_issue = 1'b0; ex_rd = 0; id_src_used = '0; ex_src = '0;
        for (int k = 0; k < 4; k++) step();
        clr();

        // Structural stall, and an illegal issue while busy.
        lo_issue = 1'b1; ex_rd = 9;
        step();
        lo_issue = 1'b0; ex_rd = 0;
        step();
        id_is_lo = 1'b1; lo_issue = 1'b1; ex_rd = 3;
        sample(); check("struct_c2", 32'(stall), 32'd1); advance();
        lo_issue = 1'b0; ex_rd = 0;
        sample();
        check("perr_set",   32'(proto_err), 32'd1);
        check("done_kept",  32'(lo_done),   32'd1);
        check("rd_kept",    32'(lo_rd),     32'd9);
        check("struct_c3",  32'(stall),     32'd0);
        advance();
        id_is_lo = 1'b0;
        step();
        step();

        // Reset in the middle of a fresh long op abandons it.
        do_reset();
        lo_issue = 1'b1; ex_rd = 12;
        step();
        lo_issue = 1'b0; ex_rd = 0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        check("mid_rst_busy", 32'(lo_busy),   32'd0);
        check("mid_rst_done", 32'(lo_done),   32'd0);
        check("mid_rst_rd",   32'(lo_rd),     32'd0);
        check("mid_rst_perr", 32'(proto_err), 32'd0);
        check("mid_rst_scnt", 32'(stall_cnt), 32'd0);
        advance();
        step();

        // Ten stall cycles saturate a 3-bit counter at 7.
        ex_mem_read = 1'b1; ex_rd = 3; id_src = {5'd0, 5'd3}; id_src_used = 2'b01;
        for (int k = 0; k < 10; k++) step();
        clr();
        sample(); check("scnt_sat", 32'(stall_cnt), 32'd7); advance();

        // Random traffic over a small register range to provoke collisions.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rst         = ($urandom_range(0, 63) == 0);
            id_src      = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            id_src_used = NS'($urandom_range(0, 3));
            id_is_lo    = ($urandom_range(0, 3) == 0);
            ex_src      = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            ex_rd       = AW'($urandom_range(0, 7));
            ex_mem_read = ($urandom_range(0, 3) == 0);
            lo_issue    = ($urandom_range(0, 3) == 0);
            exm_rd      = AW'($urandom_range(0, 7));
            exm_wr      = 1'($urandom_range(0, 1));
            wb_rd       = AW'($urandom_range(0, 7));
            wb_wr       = 1'($urandom_range(0, 1));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised forwarding, stall and long-latency scoreboard unit for the MIPS pipeline. It sits between ID/ID-EX and the EX stage and extends EX/MEM and MEM/WB operand forwarding to N source operands. It also adds load-use stall detection and tracks a single outstanding multi-cycle operation (multiply/divide unit) with a countdown scoreboard. It forwards that unit's result on completion and keeps a saturating stall-cycle counter for performance measurement.

## Interface
- REG_AW, 5, register address width
- NUM_SRC, 2, source operands per instruction (≥1)
- LO_LAT, 4, long-op latency in cycles including the issue cycle (≥2)
- STALL_CW, 16, stall counter width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_src  in  NUM_SRC*REG_AW  ID-stage source register numbers; operand i at bits [i*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  per-operand "actually read" flag
- id_is_lo  in  1  ID instruction is a long op
- ex_src  in  NUM_SRC*REG_AW  ID/EX-latched source registers
- ex_rd  in  REG_AW  ID/EX destination register
- ex_mem_read  in  1  ID/EX instruction is a load
- lo_issue  in  1  long op in EX this cycle (starts unit)
- exm_rd  in  REG_AW  EX/MEM destination register
- exm_wr  in  1  EX/MEM RegWrite
- wb_rd  in  REG_AW  MEM/WB destination register
- wb_wr  in  1  MEM/WB RegWrite
- fwd_sel  out  2*NUM_SRC  per-EX-operand mux select; 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 long-unit result
- stall  out  1  freeze PC/IF-ID, bubble ID/EX
- lo_busy  out  1  long op outstanding
- lo_done  out  1  long-unit result valid this cycle
- lo_rd  out  REG_AW  destination of outstanding long op
- proto_err  out  1  sticky; lo_issue while busy
- stall_cnt  out  STALL_CW  saturating count of stall cycles

## Operation
- Forwarding (combinational, per operand i, priority order):
  - exm_wr && exm_rd≠0 && exm_rd==ex_src[i] → 10
  - else lo_done && lo_rd≠0 && lo_rd==ex_src[i] → 11
  - else wb_wr && wb_rd≠0 && wb_rd==ex_src[i] → 01
  - else → 00
- Register 0 never matches in any comparison.
- Stall (combinational) = OR of:
  - load-use: ex_mem_read && ex_rd≠0 && ex_rd equals any id_src[i] with id_src_used[i]
  - long-op RAW: (lo_busy || lo_issue) && tracked dest ≠0 && tracked dest equals any used id_src[i]. Tracked dest is lo_rd when busy and ex_rd when lo_issue.
  - structural: id_is_lo && lo_busy && !lo_done
- Long-op FSM, states IDLE and BUSY:
  - IDLE + lo_issue → BUSY; lo_rd←ex_rd, cnt←LO_LAT−1.
  - BUSY: cnt decrements each cycle. lo_done=1 when cnt==1; the next state is IDLE.
  - BUSY + lo_issue (including the done cycle) → ignored, proto_err←1. This is a protocol violation and the FSM is unaffected.
  - lo_busy=1 in BUSY.
- cnt width is clog2(LO_LAT).
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.

## Timing
- Reset values: FSM IDLE, cnt=0, lo_rd=0, lo_busy=0, lo_done=0, proto_err=0, stall_cnt=0. fwd_sel and stall follow inputs combinationally, and lo terms are 0 while in reset state.
- rst asserted mid-operation abandons the long op: IDLE next cycle, no lo_done pulse.
- Issue in cycle 0 gives BUSY in cycles 1..LO_LAT−1, lo_done in cycle LO_LAT−1, and IDLE in cycle LO_LAT. A new issue is legal in cycle LO_LAT.
- LO_LAT=2 gives a single BUSY cycle that is also the done cycle.
- Stall is asserted in the same cycle as the hazard, with no added latency.
- In the done cycle, a dependent ID op still stalls. When released the next cycle, it gets its operand from MEM/WB or the regfile.
- Simultaneous EX/MEM, long-unit and MEM/WB matches resolve per the priority above.

## Test plan
- EX/MEM and MEM/WB both write r5; ex_src0=5 → fwd_sel[1:0]=10. Drop exm_wr → 01. exm_rd=0 with ex_src0=0 → 00.
- ex_mem_read=1, ex_rd=8, id_src1=8, id_src_used=2'b10 → stall=1. Repeat with id_src_used=2'b00 → stall=0. stall_cnt counts 1.
- LO_LAT=4: lo_issue at cycle 0 with ex_rd=12 → lo_busy cycles 1–3, lo_done only in cycle 3 with lo_rd=12. ex_src0=12 in cycle 3 with no EX/MEM match → fwd_sel=11.
- id_src0=12 used in cycles 0–3 → stall=1 in cycles 0–3 and 0 in cycle 4. id_is_lo in cycle 2 → stall; in cycle 3 → no stall.
- lo_issue at cycle 2 while busy → proto_err=1 sticky; done still in cycle 3. rst in cycle 2 of a fresh op → no lo_done, all outputs at reset values.
- STALL_CW=3, stall held 10 cycles → stall_cnt saturates at 7.
